// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: Avalon-MM slave bus between the CPU and the sample FIFO
interface audio_sample_fifo_if #(
    parameter int DATA_W = 16
) ();
    logic              chipselect;
    logic [2:0]        address;
    logic              read_n;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport slave (
        input  chipselect, address, read_n, write_n, writedata,
        output readdata
    );

    modport master (
        output chipselect, address, read_n, write_n, writedata,
        input  readdata
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: timer-paced audio sample capture FIFO drained over Avalon-MM with threshold/overflow irq
module audio_sample_fifo #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 256,
    parameter int PTR_W          = 8,
    parameter int DEFAULT_THRESH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick_i,
    input  logic [DATA_W-1:0]   sample_in_i,
    audio_sample_fifo_if.slave  av,
    output logic                irq_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    level_q, level_d, thresh_q, thresh_d;
    logic              overflow_q, overflow_d, cap_en_q, cap_en_d, irq_en_q, irq_en_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q;
    logic              rd, wr, empty, full, flush, pop, push_req, push, ovf_set, thresh_hit;
    logic              unused_wdata;

    assign unused_wdata = &{1'b0, av.writedata[DATA_W-1:PTR_W+1]};

    // Bus decode and FIFO control; flush overrides any same-cycle push or pop.
    always_comb begin
        rd         = av.chipselect & ~av.read_n;
        wr         = av.chipselect & ~av.write_n;
        empty      = level_q == '0;
        full       = level_q == (PTR_W+1)'(DEPTH);
        flush      = wr && av.address == 3'd3 && av.writedata[2];
        pop        = rd && av.address == 3'd0 && !empty && !flush;
        push_req   = sample_tick_i & cap_en_q;
        push       = push_req && (!full || pop) && !flush;
        ovf_set    = push_req && full && !pop && !flush;
        thresh_hit = thresh_q != '0 && level_q >= thresh_q;
        rd_ptr_d   = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + PTR_W'(push);
        level_d    = flush ? '0 : level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        overflow_d = flush ? 1'b0 : ovf_set ? 1'b1 : (wr && av.address == 3'd1) ? 1'b0 : overflow_q;
        cap_en_d   = (wr && av.address == 3'd3) ? av.writedata[0] : cap_en_q;
        irq_en_d   = (wr && av.address == 3'd3) ? av.writedata[1] : irq_en_q;
        thresh_d   = (wr && av.address == 3'd4) ? av.writedata[PTR_W:0] : thresh_q;
        readdata_d = av.address == 3'd0 ? ((empty || flush) ? '0 : mem[rd_ptr_q]) :
                     av.address == 3'd1 ? DATA_W'({thresh_hit, overflow_q, full, empty}) :
                     av.address == 3'd2 ? DATA_W'(level_q) :
                     av.address == 3'd3 ? DATA_W'({irq_en_q, cap_en_q}) :
                     av.address == 3'd4 ? DATA_W'(thresh_q) : '0;
    end

    // Sample storage has no reset; empty entries are never read out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sample_in_i;
    end

    // Control/status state; irq samples the already-updated flags, so it trails them by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            cap_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= (PTR_W+1)'(DEFAULT_THRESH);
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cap_en_q   <= cap_en_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_en_q & (thresh_hit | overflow_q);
        end
    end

    assign av.readdata = readdata_q;
    assign irq_o       = irq_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: scoreboard-driven check of capture, drain, threshold irq, overflow and flush
module tb_audio_sample_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] sample_in = '0;
    logic        irq;
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    audio_sample_fifo_if #(.DATA_W(16)) av ();

    audio_sample_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick_i (sample_tick),
        .sample_in_i   (sample_in),
        .av            (av.slave),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_cycle(input logic t, input logic [15:0] s, input logic r, input logic w,
                             input logic [2:0] a, input logic [15:0] wd, output logic [15:0] rdv);
        @(negedge clk);
        sample_tick   = t;
        sample_in     = s;
        av.chipselect = r | w;
        av.read_n     = ~r;
        av.write_n    = ~w;
        av.address    = a;
        av.writedata  = wd;
        @(negedge clk);
        rdv           = av.readdata;
        sample_tick   = 1'b0;
        av.chipselect = 1'b0;
        av.read_n     = 1'b1;
        av.write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
        bus_cycle(1'b0, 16'h0, 1'b1, 1'b0, a, 16'h0, v);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] v;
        bus_cycle(1'b0, 16'h0, 1'b0, 1'b1, a, d, v);
    endtask

    task automatic do_tick(input logic [15:0] s);
        logic [15:0] v;
        bus_cycle(1'b1, s, 1'b0, 1'b0, 3'd0, 16'h0, v);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        logic [15:0] exp_regs [5] = '{16'h0, 16'h0001, 16'h0, 16'h0, 16'd128};
        reset = 1'b1;
        av.chipselect = 1'b0; av.read_n = 1'b1; av.write_n = 1'b1; av.address = '0; av.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_reg(3'(i), v);
            n_checks++;
            if (v !== exp_regs[i]) begin $display("FAIL reset_reg%0d got %h want %h", i, v, exp_regs[i]); n_fail++; end
        end
        n_checks++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq got %b want 0", irq); n_fail++; end
    endtask

    task automatic test_threshold;
        logic [15:0] v, e;
        wr_reg(3'd3, 16'h3);
        wr_reg(3'd4, 16'd4);
        for (int i = 1; i <= 4; i++) begin
            do_tick(16'h1111 * 16'(i));
            exp_q.push_back(16'h1111 * 16'(i));
        end
        n_checks++;
        if (irq !== 1'b0) begin $display("FAIL thr_irq_lag got %b want 0", irq); n_fail++; end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin $display("FAIL thr_irq_rise got %b want 1", irq); n_fail++; end
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd4) begin $display("FAIL thr_level got %h want 4", v); n_fail++; end
        for (int i = 0; i < 4; i++) begin
            rd_reg(3'd0, v);
            e = exp_q.pop_front();
            n_checks++;
            if (v !== e) begin $display("FAIL thr_data%0d got %h want %h", i, v, e); n_fail++; end
        end
        n_checks++;
        if (irq !== 1'b0) begin $display("FAIL thr_irq_drop got %b want 0", irq); n_fail++; end
    endtask

    task automatic test_overflow;
        logic [15:0] v, e, s;
        wr_reg(3'd4, 16'd128);
        wr_reg(3'd3, 16'h1);
        for (int i = 0; i < 257; i++) begin
            s = 16'($urandom);
            do_tick(s);
            if (i < 256) exp_q.push_back(s);
        end
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd256) begin $display("FAIL ovf_level got %h want 0100", v); n_fail++; end
        rd_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h000E) begin $display("FAIL ovf_status got %h want 000e", v); n_fail++; end
        rd_reg(3'd0, v);
        e = exp_q.pop_front();
        n_checks++;
        if (v !== e) begin $display("FAIL ovf_first got %h want %h", v, e); n_fail++; end
        wr_reg(3'd1, 16'h0);
        rd_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h0008) begin $display("FAIL ovf_clear got %h want 0008", v); n_fail++; end
        for (int i = 0; i < 255; i++) begin
            rd_reg(3'd0, v);
            e = exp_q.pop_front();
            n_checks++;
            if (v !== e) begin $display("FAIL ovf_drain%0d got %h want %h", i, v, e); n_fail++; end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v, e, s;
        wr_reg(3'd3, 16'h1);
        for (int i = 0; i < 256; i++) begin
            s = 16'($urandom);
            do_tick(s);
            exp_q.push_back(s);
        end
        bus_cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 3'd0, 16'h0, v);
        e = exp_q.pop_front();
        exp_q.push_back(16'hBEEF);
        n_checks++;
        if (v !== e) begin $display("FAIL b2b_pop got %h want %h", v, e); n_fail++; end
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd256) begin $display("FAIL b2b_level got %h want 0100", v); n_fail++; end
        rd_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h000A) begin $display("FAIL b2b_status got %h want 000a", v); n_fail++; end
        for (int i = 0; i < 256; i++) begin
            rd_reg(3'd0, v);
            e = exp_q.pop_front();
            n_checks++;
            if (v !== e) begin $display("FAIL b2b_drain%0d got %h want %h", i, v, e); n_fail++; end
        end
        n_checks++;
        if (v !== 16'hBEEF) begin $display("FAIL b2b_last got %h want beef", v); n_fail++; end
        rd_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h0001) begin $display("FAIL b2b_empty got %h want 0001", v); n_fail++; end
    endtask

    task automatic test_flush;
        logic [15:0] v;
        wr_reg(3'd3, 16'h1);
        for (int i = 0; i < 10; i++) do_tick(16'(i + 16'h100));
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd10) begin $display("FAIL fl_pre_level got %h want 000a", v); n_fail++; end
        bus_cycle(1'b1, 16'hDEAD, 1'b0, 1'b1, 3'd3, 16'h7, v);
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd0) begin $display("FAIL fl_level got %h want 0", v); n_fail++; end
        rd_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h0001) begin $display("FAIL fl_status got %h want 0001", v); n_fail++; end
        rd_reg(3'd3, v);
        n_checks++;
        if (v !== 16'h0003) begin $display("FAIL fl_control got %h want 0003", v); n_fail++; end
    endtask

    task automatic test_empty_and_disable;
        logic [15:0] v;
        rd_reg(3'd0, v);
        n_checks++;
        if (v !== 16'h0) begin $display("FAIL emp_data got %h want 0", v); n_fail++; end
        wr_reg(3'd3, 16'h0);
        repeat (3) do_tick(16'h7777);
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd0) begin $display("FAIL dis_level got %h want 0", v); n_fail++; end
        wr_reg(3'd3, 16'h1);
        do_tick(16'h5A5A);
        rd_reg(3'd0, v);
        n_checks++;
        if (v !== 16'h5A5A) begin $display("FAIL emp_ptr got %h want 5a5a", v); n_fail++; end
    endtask

    task automatic test_reset_midfill;
        logic [15:0] v;
        wr_reg(3'd3, 16'h3);
        wr_reg(3'd4, 16'd2);
        repeat (3) do_tick(16'h3C3C);
        rd_reg(3'd2, v);
        n_checks++;
        if (irq !== 1'b1) begin $display("FAIL rst_irq_pre got %b want 1", irq); n_fail++; end
        n_checks++;
        if (v !== 16'd3) begin $display("FAIL rst_level_pre got %h want 0003", v); n_fail++; end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (irq !== 1'b0) begin $display("FAIL rst_irq_async got %b want 0", irq); n_fail++; end
        n_checks++;
        if (av.readdata !== 16'h0) begin $display("FAIL rst_rdata_async got %h want 0", av.readdata); n_fail++; end
        @(negedge clk);
        reset = 1'b0;
        rd_reg(3'd2, v);
        n_checks++;
        if (v !== 16'd0) begin $display("FAIL rst_level got %h want 0", v); n_fail++; end
        rd_reg(3'd4, v);
        n_checks++;
        if (v !== 16'd128) begin $display("FAIL rst_thresh got %h want 0080", v); n_fail++; end
        rd_reg(3'd3, v);
        n_checks++;
        if (v !== 16'h0) begin $display("FAIL rst_control got %h want 0", v); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_empty_and_disable();
        test_reset_midfill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Downstream consumer of the interval timer's periodic timeout. On each timer tick, while capture is enabled, the block captures one 16-bit audio sample from the codec-side sample bus into an on-chip FIFO.
- The CPU drains the FIFO over an Avalon-MM slave with registered readdata.
- irq asserts when the FIFO level reaches a programmable threshold or on overflow. This lets the ASR software process audio in blocks rather than once per sample.

Parameters:
DATA_W, 16, sample and register data width
DEPTH, 256, FIFO entries (power of two)
PTR_W, 8, log2(DEPTH)
DEFAULT_THRESH, 128, reset value of THRESH register

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  one-cycle pulse from timer timeout (period expiry)
sample_in  input  DATA_W  current codec sample, stable when sample_tick is high
chipselect  input  1  Avalon slave select
address  input  3  register select
read_n  input  1  active-low read strobe
write_n  input  1  active-low write strobe
writedata  input  DATA_W  write data
readdata  output  DATA_W  registered read data
irq  output  1  level interrupt to CPU

Behaviour:
- Reset (async, reset=1) clears the following:
  - rd_ptr, wr_ptr and level (PTR_W+1 bits) go to 0.
  - overflow goes to 0, and CONTROL goes to 0.
  - THRESH goes to DEFAULT_THRESH.
  - readdata and irq go to 0.
  - FIFO contents are undefined, and are never observable while empty.
- Register map, with rd = chipselect & ~read_n and wr = chipselect & ~write_n:
  - 0 DATA (RO): head sample. rd pops it.
  - 1 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 thresh_hit, other bits 0. Any wr clears overflow.
  - 2 LEVEL (RO): level zero-extended to DATA_W.
  - 3 CONTROL: bit0 cap_en, bit1 irq_en, bit2 flush (write-1 pulse, reads 0). Other bits read 0.
  - 4 THRESH (RW): low PTR_W+1 bits significant, upper bits read 0.
  - 5-7: read 0, writes ignored.
- Read timing:
  - readdata <= read_mux_out every cycle, so data appears 1 cycle after the address is presented.
  - For address 0, the mux outputs mem[rd_ptr] when not empty and 0 when empty.
  - The pop (rd_ptr+1, level-1) occurs in the same edge that registers the data.
  - A read of DATA when empty returns 0 and does not change the pointers.
  - Writes to RO registers are ignored.
- Push:
  - A push occurs when sample_tick & cap_en.
  - If not full: mem[wr_ptr] <= sample_in, wr_ptr+1, level+1.
  - If full: the sample is dropped, overflow <= 1, and pointers are unchanged.
  - A tick while cap_en=0 is ignored.
- Simultaneous push and pop in one cycle:
  - Not empty and not full: both happen, level unchanged.
  - Empty: the push proceeds. The pop is not performed and readdata=0.
  - Full: the pop frees an entry, so the push is accepted, level stays DEPTH, and overflow is not set.
- Pointers wrap modulo DEPTH. Status flags are derived from level: empty when level==0, full when level==DEPTH.
- Flush:
  - A CONTROL write with writedata[2]=1 zeroes the pointers and level and clears overflow on that edge.
  - The same write still updates cap_en and irq_en.
  - Flush beats a concurrent push or pop: the tick sample is dropped, no overflow is flagged, and a concurrent pop read returns 0.
- thresh_hit = (THRESH != 0) & (level >= THRESH). THRESH=0 disables the threshold term.
- irq is registered: irq <= irq_en & (thresh_hit | overflow), evaluated on post-update state, so it lags by 1 cycle.
- Overflow clears only on a STATUS write, a flush, or reset. If a STATUS write coincides with an overflowing push, the set wins and overflow=1.
- Reset asserted mid-transfer: everything returns to reset values immediately. No partial state survives.

Test Plan:
- Reset, then read addresses 0-4 -> readdata 0, 0x0001 (empty), 0, 0, 128. irq=0.
- CONTROL=0x3, THRESH=4, apply 4 ticks with sample_in 0x1111..0x4444 -> LEVEL=4. irq rises 1 cycle after the 4th push. Four DATA reads return 0x1111, 0x2222, 0x3333, 0x4444 in order, and irq drops after level<4.
- CONTROL=0x1 with 257 ticks and no reads -> LEVEL=256, STATUS=0x000E (full, overflow, thresh_hit at 128). The first DATA read returns the 1st sample, not the 257th. A STATUS write clears bit2.
- Fill to 256, then a tick coincident with a DATA read -> the pop returns the oldest sample and the new sample is accepted. LEVEL stays 256, overflow stays 0, and the last read of the full drain returns the coincident sample.
- Level 10, CONTROL write 0x7 on the same cycle as a tick -> LEVEL=0, STATUS=0x0001, flush bit reads 0, and cap_en/irq_en remain set.
- Read DATA while empty -> readdata 0, pointers unchanged. With cap_en=0, ticks do not change LEVEL. Asserting reset mid-fill returns LEVEL=0 and irq=0 asynchronously.
